// File: rtl/gpio_debounce.sv
// Per-channel debouncer: 2-flop synchronizer, then a STABLE/CHANGING FSM that accepts a level after STABLE_CNT+1 agreeing samples.
// Latency: dout (and rise/fall) change STABLE_CNT+3 edges after din settles. No backpressure; free-running.
// Optional DEBOUNCE_EDGE_EN builds the rise/fall pulse registers; when undefined, rise/fall are tied to 0.
module gpio_debounce #(
    parameter int N          = 5,
    parameter int CNT_W      = 20,
    parameter int STABLE_CNT = 1000000
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    typedef enum logic {STABLE = 1'b0, CHANGING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic [N-1:0]     sync1_q, sync2_q;
    logic [N-1:0]     dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q   [N];
    logic [CNT_W-1:0] cnt_d   [N];
    state_t           state_q [N];
    state_t           state_d [N];

    // State register: synchronizer, FSM state, counter, accepted level.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dout_q  <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                STABLE: begin
                    if (sync2_q[i] != dout_q[i]) state_d[i] = CHANGING;
                end
                CHANGING: begin
                    if (sync2_q[i] == dout_q[i] || cnt_q[i] == CNT_MAX) state_d[i] = STABLE;
                end
                default: state_d[i] = STABLE;
            endcase
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    logic [N-1:0] rise_q, rise_d;
    logic [N-1:0] fall_q, fall_d;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif

    // Output/datapath logic: a bounce back to dout restarts the count from zero.
    always_comb begin
        dout_d = dout_q;
`ifdef DEBOUNCE_EDGE_EN
        rise_d = '0;
        fall_d = '0;
`endif
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            case (state_q[i])
                STABLE: begin
                    cnt_d[i] = '0;
                end
                CHANGING: begin
                    if (sync2_q[i] == dout_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        cnt_d[i]  = '0;
                        dout_d[i] = sync2_q[i];
`ifdef DEBOUNCE_EDGE_EN
                        rise_d[i] = sync2_q[i];
                        fall_d[i] = ~sync2_q[i];
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: cnt_d[i] = '0;
            endcase
        end
    end

    assign dout = dout_q;

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 Parameter N, default 5: number of independent input channels.
REQ-002 Parameter CNT_W, default 20: width of each channel's stability counter.
REQ-003 Parameter STABLE_CNT, default 1000000: consecutive stable cycles required to accept a change (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-004 ACLK  input  1  clock; all state on rising edge.
REQ-005 ARESETn  input  1  reset, asynchronous, active-low.
REQ-006 din  input  N  raw asynchronous button/switch levels.
REQ-007 dout  output  N  debounced, ACLK-synchronous levels, fed to the GPIO register block's button/switch inputs.
REQ-008 rise  output  N  one-cycle pulse per channel on an accepted 0->1 change of dout.
REQ-009 fall  output  N  one-cycle pulse per channel on an accepted 1->0 change of dout.

Function
REQ-010 Each din bit SHALL pass a two-flop synchronizer; only the second-stage output (sync) feeds the logic below.
REQ-011 Each channel SHALL have its own FSM {STABLE, CHANGING} and counter cnt[CNT_W-1:0]; channels are fully independent.
REQ-012 STABLE: sync==dout -> stay; sync!=dout -> CHANGING, cnt<=0.
REQ-013 CHANGING: sync==dout -> STABLE, cnt<=0, dout unchanged (glitch rejected, no pulse).
REQ-014 CHANGING: sync!=dout and cnt<STABLE_CNT-1 -> cnt<=cnt+1.
REQ-015 CHANGING: sync!=dout and cnt==STABLE_CNT-1 -> dout<=sync, STABLE, cnt<=0, matching rise/fall pulse asserted in the same cycle as dout changes.
REQ-016 Latency: with din stable before rising edge E1, dout SHALL change on edge E(STABLE_CNT+3) and not earlier.
REQ-017 Any input disturbance shorter than STABLE_CNT+1 sync cycles SHALL produce no dout change and no pulse.
REQ-018 Each bounce back to the current dout level restarts the full count; the count never saturates or wraps.
REQ-019 rise/fall SHALL be high for exactly one cycle per accepted change and never simultaneously on one channel.
REQ-020 Simultaneous changes on several channels SHALL each complete at their own latency with no interaction.

Reset
REQ-021 ARESETn low SHALL asynchronously force synchronizer flops, dout, rise, fall, cnt to 0 and every FSM to STABLE.
REQ-022 Reset during CHANGING SHALL discard the pending change; after release, a full REQ-016 latency is required.
REQ-023 After release with din all-high, dout SHALL rise at edge STABLE_CNT+3 with rise pulses (reset value is 0, not din).

Configuration
REQ-024 Macro DEBOUNCE_EDGE_EN defined: rise/fall pulse logic present and behaves per REQ-015/019.
REQ-025 Macro DEBOUNCE_EDGE_EN undefined: rise and fall ports still exist, are driven constant 0, and no pulse registers are built; dout behaviour is identical.

Verification (STABLE_CNT=4, N=5, CNT_W=4)
REQ-026 Reset asserted, din=5'h1F -> dout=0, rise=0, fall=0 throughout reset.
REQ-027 din[0] 0->1 before E1, held -> dout[0]=1 and rise[0]=1 at E7 only; rise[0]=0 at E8; fall=0 throughout.
REQ-028 din[2] high for 3 cycles then low -> dout[2] stays 0, rise[2]/fall[2] never pulse.
REQ-029 din[3] toggles 1,0,1 every 2 cycles then holds 1 -> dout[3]=1 exactly 7 edges after the last transition; single rise[3] pulse.
REQ-030 din[1] rises at E1, din[4] rises at E3 -> dout[1] at E7, dout[4] at E9; later din[1] falls -> fall[1] pulses 7 edges later.
REQ-031 din[0] rises at E1, ARESETn pulsed low between E5 and E6 -> dout[0]=0 at E7; dout[0]=1 with rise[0] 7 edges after first post-reset edge; rerun with DEBOUNCE_EDGE_EN undefined -> rise/fall stay 0, dout identical.
